// File: rtl/cordic_rotation_sequencer.sv
// Iterative rotation-mode CORDIC: takes a binary angle (2^32 = full circle) and
// returns cos/sin in signed Q2.30 after ITERATIONS micro-rotations.
module cordic_rotation_sequencer #(
   parameter int          ITERATIONS = 16,
   parameter logic [31:0] INIT_X     = 32'h26DD3B6A
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_angle,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_cos,
   output logic [31:0] out_sin
);

   localparam logic [4:0] LAST_ITER = 5'(ITERATIONS - 1);

   typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_CORRECT, S_DONE} state_t;

   state_t             r_state;
   state_t             w_next;
   logic signed [31:0] r_x;
   logic signed [31:0] r_y;
   logic signed [31:0] r_z;
   logic [4:0]         r_iter;
   logic               r_negate;

   logic signed [31:0] w_x_sh;
   logic signed [31:0] w_y_sh;
   logic signed [31:0] w_atan;
   logic               w_d;
   logic               w_reduce;

   // round(atan(2^-i) * 2^31 / pi); indices past 29 are never reached
   function automatic logic [31:0] atan_lut(input logic [4:0] idx);
      case (idx)
         5'd0:    return 32'h20000000;
         5'd1:    return 32'h12E4051E;
         5'd2:    return 32'h09FB385B;
         5'd3:    return 32'h051111D4;
         5'd4:    return 32'h028B0D43;
         5'd5:    return 32'h0145D7E1;
         5'd6:    return 32'h00A2F61E;
         5'd7:    return 32'h00517C55;
         5'd8:    return 32'h0028BE53;
         5'd9:    return 32'h00145F2F;
         5'd10:   return 32'h000A2F98;
         5'd11:   return 32'h000517CC;
         5'd12:   return 32'h00028BE6;
         5'd13:   return 32'h000145F3;
         5'd14:   return 32'h0000A2FA;
         5'd15:   return 32'h0000517D;
         5'd16:   return 32'h000028BE;
         5'd17:   return 32'h0000145F;
         5'd18:   return 32'h00000A30;
         5'd19:   return 32'h00000518;
         5'd20:   return 32'h0000028C;
         5'd21:   return 32'h00000146;
         5'd22:   return 32'h000000A3;
         5'd23:   return 32'h00000051;
         5'd24:   return 32'h00000029;
         5'd25:   return 32'h00000014;
         5'd26:   return 32'h0000000A;
         5'd27:   return 32'h00000005;
         5'd28:   return 32'h00000003;
         5'd29:   return 32'h00000001;
         default: return 32'h00000000;
      endcase
   endfunction

   assign w_x_sh    = r_x >>> r_iter;
   assign w_y_sh    = r_y >>> r_iter;
   assign w_atan    = atan_lut(r_iter);
   assign w_d       = r_z[31];
   // Quadrants 2 and 3 are folded by 180 degrees; the result is negated later
   assign w_reduce  = in_angle[31] ^ in_angle[30];
   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (in_valid) w_next = S_ROTATE;
         S_ROTATE:  if (r_iter == LAST_ITER) w_next = S_CORRECT;
         S_CORRECT: w_next = S_DONE;
         S_DONE:    if (out_ready) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_x      <= '0;
         r_y      <= '0;
         r_z      <= '0;
         r_iter   <= '0;
         r_negate <= 1'b0;
         out_cos  <= '0;
         out_sin  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_x      <= INIT_X;
                  r_y      <= '0;
                  r_iter   <= '0;
                  r_negate <= w_reduce;
                  r_z      <= w_reduce ? (in_angle + 32'h80000000) : in_angle;
               end
            end
            S_ROTATE: begin
               if (w_d) begin
                  r_x <= r_x + w_y_sh;
                  r_y <= r_y - w_x_sh;
                  r_z <= r_z + w_atan;
               end else begin
                  r_x <= r_x - w_y_sh;
                  r_y <= r_y + w_x_sh;
                  r_z <= r_z - w_atan;
               end
               r_iter <= r_iter + 5'd1;
            end
            S_CORRECT: begin
               out_cos <= r_negate ? -r_x : r_x;
               out_sin <= r_negate ? -r_y : r_y;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_rotation_sequencer.sv
// Bench for cordic_rotation_sequencer: directed corner angles, backpressure,
// back-to-back source, mid-rotation reset and random angles vs real-math cos/sin.
module tb_cordic_rotation_sequencer;

   localparam int  ITER = 16;
   localparam int  TOL  = 32'h8000;
   localparam real PI   = 3.14159265358979323846;

   logic        clock     = 1'b0;
   logic        reset_n   = 1'b1;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_angle  = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_cos;
   logic [31:0] out_sin;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   cordic_rotation_sequencer #(.ITERATIONS(ITER), .INIT_X(32'h26DD3B6A)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_angle  (in_angle),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_cos   (out_cos),
      .out_sin   (out_sin)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp, input int tol);
      longint d;
      d = longint'($signed(got)) - longint'($signed(exp));
      if (d < 0) d = -d;
      n_checks++;
      if (d <= longint'(tol)) n_pass++;
      else $display("FAIL %s: got %h expected %h (tol %0d)", tag, got, exp, tol);
   endtask

   function automatic logic [31:0] q30(input real v);
      longint r;
      r = longint'(v * 1073741824.0);
      return r[31:0];
   endfunction

   function automatic real ang_rad(input logic [31:0] a);
      return 2.0 * PI * real'(a) / 4294967296.0;
   endfunction

   function automatic logic [31:0] ref_cos(input logic [31:0] a);
      return q30($cos(ang_rad(a)));
   endfunction

   function automatic logic [31:0] ref_sin(input logic [31:0] a);
      return q30($sin(ang_rad(a)));
   endfunction

   task automatic send(input logic [31:0] a);
      int w;
      @(negedge clock);
      in_angle = a;
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clock);
         w++;
      end
      check("accept_ready", 32'(in_ready), 32'd1, 0);
      @(posedge clock);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      do begin
         @(posedge clock);
         #1 lat++;
      end while (!out_valid && lat < 100);
   endtask

   task automatic release_result(input string tag);
      @(negedge clock);
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      check({tag, "_vld_clr"}, 32'(out_valid), 32'd0, 0);
      check({tag, "_rdy_back"}, 32'(in_ready), 32'd1, 0);
      out_ready = 1'b0;
   endtask

   task automatic run_angle(input string tag, input logic [31:0] a, input logic [31:0] ec, input logic [31:0] es);
      int lat;
      send(a);
      wait_result(lat);
      check({tag, "_lat"}, 32'(lat), 32'(ITER + 1), 0);
      check({tag, "_cos"}, out_cos, ec, TOL);
      check({tag, "_sin"}, out_sin, es, TOL);
      release_result(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      logic [31:0] b2b [3];
      int          t_acc [3];
      int          lat;
      int          w;
      logic        seen;

      #1 reset_n = 1'b0;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1, 0);
      check("rst_out_valid", 32'(out_valid), 32'd0, 0);
      check("rst_cos", out_cos, 32'd0, 0);
      check("rst_sin", out_sin, 32'd0, 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      run_angle("a0",   32'h00000000, 32'h40000000, 32'h00000000);
      run_angle("a90",  32'h40000000, 32'h00000000, 32'h40000000);
      run_angle("a180", 32'h80000000, 32'hC0000000, 32'h00000000);
      run_angle("am45", 32'hE0000000, 32'h2D413CCD, 32'hD2BEC333);
      run_angle("a270", 32'hC0000000, 32'h00000000, 32'hC0000000);

      // Backpressure: result held while the consumer stalls, requests ignored
      a = 32'h11111111;
      send(a);
      wait_result(lat);
      check("bp_lat", 32'(lat), 32'(ITER + 1), 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         in_valid = 1'b1;
         in_angle = $urandom;
         check("bp_vld", 32'(out_valid), 32'd1, 0);
         check("bp_rdy", 32'(in_ready), 32'd0, 0);
         check("bp_cos", out_cos, ref_cos(a), TOL);
         check("bp_sin", out_sin, ref_sin(a), TOL);
      end
      @(negedge clock);
      in_valid = 1'b0;
      release_result("bp");
      seen = 1'b0;
      repeat (25) begin
         @(negedge clock);
         seen |= out_valid;
      end
      check("bp_ignored", 32'(seen), 32'd0, 0);

      // Back-to-back: source holds in_valid high across three angles
      for (int k = 0; k < 3; k++) b2b[k] = $urandom;
      out_ready = 1'b1;
      @(negedge clock);
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_angle = b2b[k];
         w = 0;
         while (!in_ready && w < 100) begin
            @(negedge clock);
            w++;
         end
         t_acc[k] = cyc;
         check("b2b_accept", 32'(in_ready), 32'd1, 0);
         @(posedge clock);
         #1;
         if (k == 2) in_valid = 1'b0;
         wait_result(lat);
         check("b2b_lat", 32'(lat), 32'(ITER + 1), 0);
         check("b2b_cos", out_cos, ref_cos(b2b[k]), TOL);
         check("b2b_sin", out_sin, ref_sin(b2b[k]), TOL);
         if (k > 0) check("b2b_gap", 32'((t_acc[k] - t_acc[k-1]) >= 18), 32'd1, 0);
      end
      @(negedge clock);
      seen = 1'b0;
      repeat (25) begin
         @(negedge clock);
         seen |= out_valid;
      end
      check("b2b_no_dup", 32'(seen), 32'd0, 0);
      out_ready = 1'b0;

      // Asynchronous reset while rotating at iteration 7
      send(32'h12345678);
      repeat (7) @(posedge clock);
      #3 reset_n = 1'b0;
      #1;
      check("mid_rst_cos", out_cos, 32'd0, 0);
      check("mid_rst_sin", out_sin, 32'd0, 0);
      check("mid_rst_vld", 32'(out_valid), 32'd0, 0);
      check("mid_rst_rdy", 32'(in_ready), 32'd1, 0);
      seen = 1'b0;
      repeat (3) begin
         @(negedge clock);
         seen |= out_valid;
      end
      reset_n = 1'b1;
      repeat (20) begin
         @(negedge clock);
         seen |= out_valid;
      end
      check("mid_rst_no_pulse", 32'(seen), 32'd0, 0);
      run_angle("a45", 32'h20000000, 32'h2D413CCD, 32'h2D413CCD);

      for (int k = 0; k < 20; k++) begin
         a = $urandom;
         run_angle("rnd", a, ref_cos(a), ref_sin(a));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
